spybuffer_rr_reader: RTL and testbench

- Read-side consumer for a bank of SpyBuffer FIFOs, e.g. the output spybuffers of a test top level.
- Drains N_INPUTS FIFOs through their read_enable/empty/read_data interface using round-robin arbitration.
- Merges all sources into one valid/ready stream, with each word tagged by its source index.
- Sits between the spybuffer bank and a single downstream sink, such as a monitor, serializer or readout link.

---
 rtl/spybuffer_reader_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/spybuffer_rr_reader.sv | 128 ++++++++++++
 tb/tb_spybuffer_rr_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spybuffer_reader_pkg.sv
// Shared constants, source-tag width helper and skid entry type for the spybuffer round-robin reader.
package spybuffer_reader_pkg;

   localparam int unsigned MAX_INPUTS         = 16;
   localparam int unsigned DEFAULT_DATA_WIDTH = 65;
   localparam int unsigned MAX_IDX_WIDTH      = 4;

   // Source tag width; a single source still carries a 1-bit tag.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Skid entry in the default configuration (65-bit word, widest tag).
   typedef struct packed {
      logic [DEFAULT_DATA_WIDTH-1:0] data;
      logic [MAX_IDX_WIDTH-1:0]      src;
   } skid_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_INPUTS  = 4,
   parameter int unsigned IDX_WIDTH = 2
) (
   input  logic [N_INPUTS-1:0]  req,
   input  logic [IDX_WIDTH-1:0] ptr,
   input  logic                 enable,
   output logic [N_INPUTS-1:0]  grant,
   output logic [IDX_WIDTH-1:0] grant_idx
);

   logic                 found;
   logic [IDX_WIDTH-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= N_INPUTS; k++) begin
         cand = IDX_WIDTH'((32'(ptr) + k) % N_INPUTS);
         if (enable && !found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/spybuffer_rr_reader.sv
// Round-robin drain of a SpyBuffer FIFO bank into one tagged valid/ready stream.
// Define SPY_READER_WORD_COUNT_EN to add per-source accepted-word counters (word_count).
module spybuffer_rr_reader
   import spybuffer_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned N_INPUTS   = 4,
   parameter int unsigned IDX_WIDTH  = idx_width(N_INPUTS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_INPUTS-1:0]   fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_read_data [N_INPUTS],
   output logic [N_INPUTS-1:0]   fifo_read_enable,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [IDX_WIDTH-1:0]  out_src,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef SPY_READER_WORD_COUNT_EN
   ,
   output logic [31:0]           word_count [N_INPUTS]
`endif
);

   if (N_INPUTS < 1 || N_INPUTS > MAX_INPUTS) begin : g_bad_n_inputs
      $error("spybuffer_rr_reader: N_INPUTS out of range");
   end

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [IDX_WIDTH-1:0]  src;
   } entry_t;

   entry_t               head_q, tail_q, head_d, tail_d, cap;
   logic                 head_v_q, tail_v_q, head_v_d, tail_v_d;
   logic                 inflight_q;
   logic [IDX_WIDTH-1:0] inflight_idx_q;
   logic [IDX_WIDTH-1:0] ptr_q;
   logic [N_INPUTS-1:0]  req, grant;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic [2:0]           pending;
   logic                 pop_out, issue_ok, issue;

   assign pop_out = head_v_q & out_ready;
   assign req     = ~fifo_empty;

   // Pop strobe is combinational so issue sees this cycle's occupancy; forced low while in reset.
   assign pending  = 3'(head_v_q) + 3'(tail_v_q) + 3'(inflight_q) - 3'(pop_out);
   assign issue_ok = !reset && (pending < 3'd2);

   rr_arbiter #(
      .N_INPUTS  (N_INPUTS),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_arb (
      .req       (req),
      .ptr       (ptr_q),
      .enable    (issue_ok),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign issue            = |grant;
   assign fifo_read_enable = grant;

   assign cap.data = fifo_read_data[inflight_idx_q];
   assign cap.src  = inflight_idx_q;

   // Skid buffer as a 2-deep queue: drop the accepted head, then append the captured word.
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      head_v_d = head_v_q;
      tail_v_d = tail_v_q;
      if (pop_out) begin
         head_d   = tail_q;
         head_v_d = tail_v_q;
         tail_v_d = 1'b0;
      end
      if (inflight_q) begin
         if (!head_v_d) begin
            head_d   = cap;
            head_v_d = 1'b1;
         end else begin
            tail_d   = cap;
            tail_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         head_v_q       <= 1'b0;
         tail_v_q       <= 1'b0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         ptr_q          <= IDX_WIDTH'(N_INPUTS - 1);
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         head_v_q   <= head_v_d;
         tail_v_q   <= tail_v_d;
         inflight_q <= issue;
         if (issue) begin
            inflight_idx_q <= grant_idx;
            ptr_q          <= grant_idx;
         end
      end
   end

   assign out_valid = head_v_q;
   assign out_data  = head_q.data;
   assign out_src   = head_q.src;

`ifdef SPY_READER_WORD_COUNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_INPUTS; i++) word_count[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (pop_out && head_q.src == IDX_WIDTH'(i)) word_count[i] <= word_count[i] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spybuffer_rr_reader.sv
// Bench for spybuffer_rr_reader: FIFO bank model, directed table, reset corner and random drain.
module tb_spybuffer_rr_reader;
   import spybuffer_reader_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 65;
   localparam int unsigned IW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  fifo_empty = '1;
   logic [DW-1:0] fifo_read_data [N];
   logic [N-1:0]  fifo_read_enable;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_src;
   logic          out_valid;
   logic          out_ready = 1'b0;
`ifdef SPY_READER_WORD_COUNT_EN
   logic [31:0]   word_count [N];
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] fifo_q [N][$];
   skid_entry_t   exp_q  [N][$];
   int            exp_src[$];

   spybuffer_rr_reader #(
      .DATA_WIDTH (DW),
      .N_INPUTS   (N)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .fifo_empty       (fifo_empty),
      .fifo_read_data   (fifo_read_data),
      .fifo_read_enable (fifo_read_enable),
      .out_data         (out_data),
      .out_src          (out_src),
      .out_valid        (out_valid),
      .out_ready        (out_ready)
`ifdef SPY_READER_WORD_COUNT_EN
      ,
      .word_count       (word_count)
`endif
   );

   always #5 clock = ~clock;

   // SpyBuffer model: one-cycle read latency, registered empty flag.
   always @(posedge clock) begin
      for (int i = 0; i < N; i++) begin
         if (fifo_read_enable[i] && fifo_q[i].size() > 0) fifo_read_data[i] <= fifo_q[i].pop_front();
         fifo_empty[i] <= (fifo_q[i].size() == 0);
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected source order: scan upward from the last grant, wrapping, over the remaining word counts.
   function automatic void build_model();
      int rem [N];
      int ptr;
      int left;
      exp_src.delete();
      ptr  = N - 1;
      left = 0;
      for (int i = 0; i < N; i++) begin
         rem[i] = exp_q[i].size();
         left  += rem[i];
      end
      while (left > 0) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (rem[idx] > 0) begin
               exp_src.push_back(idx);
               rem[idx]--;
               left--;
               ptr = idx;
               break;
            end
         end
      end
   endfunction

   task automatic start_test(input int cnt [N], input bit rnd);
      logic [DW-1:0] w;
      skid_entry_t   e;
      reset     = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         fifo_q[i].delete();
         exp_q[i].delete();
         for (int k = 0; k < cnt[i]; k++) begin
            w = rnd ? {1'($urandom()), $urandom(), $urandom()} : DW'(k + 1);
            fifo_q[i].push_back(w);
            e.data = w;
            e.src  = 4'(i);
            exp_q[i].push_back(e);
         end
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_src", out_src, 0);
      check("rst_rd_en", fifo_read_enable, 0);
      reset = 1'b0;
   endtask

   // Drain everything in exp_q; cycle 0 is the cycle right after reset release.
   task automatic run(input int mode, input int stall, output int n_acc, output int first_c,
                      output int last_c, output int stall_pulses);
      int            c, total, budget, s;
      bit            prev_valid, prev_ready;
      logic [DW-1:0] prev_data;
      logic [IW-1:0] prev_src;
      skid_entry_t   e;
      build_model();
      total        = exp_src.size();
      budget       = 30 + 8 * total;
      n_acc        = 0;
      first_c      = -1;
      last_c       = -1;
      stall_pulses = 0;
      prev_valid   = 1'b0;
      prev_ready   = 1'b0;
      prev_data    = '0;
      prev_src     = '0;
      c            = 0;
      while (n_acc < total && c < budget) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'(c % 2);
            2:       out_ready = (c >= stall);
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         #1;
         if (fifo_read_enable != 0) begin
            check("rd_en_onehot", $countones(fifo_read_enable), 1);
            if (mode == 2 && c < stall) stall_pulses++;
         end
         if (prev_valid && !prev_ready)
            check("hold", {out_valid, out_src, out_data}, {1'b1, prev_src, prev_data});
         if (out_valid && out_ready) begin
            if (exp_src.size() == 0) begin
               check("extra_word", 1, 0);
            end else begin
               s = exp_src.pop_front();
               e = exp_q[s].pop_front();
               check("src", out_src, s);
               check("data", out_data, e.data);
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            n_acc++;
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_src   = out_src;
         @(negedge clock);
         c++;
      end
      if (n_acc < total) check("timeout_words", n_acc, total);
   endtask

   typedef struct {
      int cnt [N];
      int mode;
      int stall;
      int exp_words;
      int exp_first;
      int exp_span;
      int exp_pulses;
   } vec_t;

   initial begin
      vec_t vt [4];
      int   n_acc, first_c, last_c, pulses;
      int   cnt [N];

      vt[0] = '{cnt: '{0, 0, 3, 0}, mode: 0, stall: 0,  exp_words: 3, exp_first: 2,  exp_span: 3,  exp_pulses: -1};
      vt[1] = '{cnt: '{2, 2, 2, 2}, mode: 0, stall: 0,  exp_words: 8, exp_first: 2,  exp_span: 8,  exp_pulses: -1};
      vt[2] = '{cnt: '{5, 0, 0, 0}, mode: 2, stall: 10, exp_words: 5, exp_first: 10, exp_span: -1, exp_pulses: 2};
      vt[3] = '{cnt: '{0, 4, 0, 4}, mode: 1, stall: 0,  exp_words: 8, exp_first: -1, exp_span: -1, exp_pulses: -1};

      @(negedge clock);
      for (int v = 0; v < 4; v++) begin
         start_test(vt[v].cnt, 1'b0);
         run(vt[v].mode, vt[v].stall, n_acc, first_c, last_c, pulses);
         check($sformatf("v%0d_words", v), n_acc, vt[v].exp_words);
         if (vt[v].exp_first >= 0) check($sformatf("v%0d_first", v), first_c, vt[v].exp_first);
         if (vt[v].exp_span >= 0) check($sformatf("v%0d_span", v), last_c - first_c + 1, vt[v].exp_span);
         if (vt[v].exp_pulses >= 0) check($sformatf("v%0d_stall_pops", v), pulses, vt[v].exp_pulses);
         check($sformatf("v%0d_idle", v), out_valid, 0);
      end

      // Reset while a word sits in the skid and another is in flight.
      cnt = '{5, 5, 0, 0};
      start_test(cnt, 1'b1);
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("pre_rst_valid", out_valid, 1);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_rd_en", fifo_read_enable, 0);
      check("async_rst_data", out_data, 0);
      void'(exp_q[0].pop_front());
      void'(exp_q[1].pop_front());
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      run(0, 0, n_acc, first_c, last_c, pulses);
      check("post_rst_words", n_acc, 8);
      check("post_rst_first", first_c, 2);

`ifdef SPY_READER_WORD_COUNT_EN
      cnt = '{3, 0, 0, 5};
      start_test(cnt, 1'b1);
      run(0, 0, n_acc, first_c, last_c, pulses);
      check("wc0", word_count[0], 3);
      check("wc1", word_count[1], 0);
      check("wc2", word_count[2], 0);
      check("wc3", word_count[3], 5);
`endif

      // Random loads with random back-pressure against the round-robin model.
      for (int r = 0; r < 8; r++) begin
         int tot;
         tot = 0;
         for (int i = 0; i < N; i++) begin
            cnt[i] = $urandom_range(0, 6);
            tot   += cnt[i];
         end
         start_test(cnt, 1'b1);
         run(3, 0, n_acc, first_c, last_c, pulses);
         check($sformatf("rnd%0d_words", r), n_acc, tot);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
